// File: rtl/vid_scan_doubler.sv
// vid_scan_doubler: line doubler between the graphics VIDOUT stream and the VGA DAC.
// Each source line is captured into a ping-pong buffer and replayed twice at 640x480 timing.
module vid_scan_doubler #(
  parameter int SRC_WIDTH    = 336,
  parameter int CROP_LEFT    = 8,
  parameter int H_TOTAL      = 800,
  parameter int H_ACTIVE     = 640,
  parameter int H_SYNC_START = 656,
  parameter int H_SYNC_END   = 752,
  parameter int PIX_DIV      = 4,
  parameter int VSYNC_LINES  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_en,
  input  logic [15:0] vidout,
  input  logic        hblank_b,
  input  logic        vblank_b,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        vga_hsync_b,
  output logic        vga_vsync_b,
  output logic        vga_de,
  output logic        line_overrun
);

  localparam int AW = $clog2(SRC_WIDTH + 1);
  localparam int HW = $clog2(H_TOTAL);
  localparam int RW = HW + 1;
  localparam int DW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam int VW = $clog2(VSYNC_LINES + 2);

  localparam logic [AW-1:0] SRC_LIM  = AW'(SRC_WIDTH);
  localparam logic [AW-1:0] ADDR_ONE = AW'(1);
  localparam logic [RW-1:0] RD_LIM   = RW'(SRC_WIDTH);
  localparam logic [RW-1:0] RD_BASE  = RW'(CROP_LEFT);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG   = HW'(H_SYNC_START);
  localparam logic [HW-1:0] HS_END   = HW'(H_SYNC_END);
  localparam logic [HW-1:0] H_ONE    = HW'(1);
  localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
  localparam logic [DW-1:0] DIV_ONE  = DW'(1);
  localparam logic [VW-1:0] VS_LAST  = VW'(VSYNC_LINES);
  localparam logic [VW-1:0] VS_DONE  = VW'(VSYNC_LINES + 1);
  localparam logic [VW-1:0] VS_ONE   = VW'(1);

  // Replay progress of the line currently in the read bank.
  typedef enum logic [1:0] {
    REP_FIRST  = 2'd0,
    REP_SECOND = 2'd1,
    REP_IDLE   = 2'd2
  } rep_e;

  logic [15:0]   mem_q [2][SRC_WIDTH];

  logic          hb_q;
  logic          vb_q;
  logic          hb_rise;
  logic          hb_fall;
  logic          vb_fall;
  logic          swap;

  logic [AW-1:0] wr_addr_q;
  logic [AW-1:0] wr_addr_d;
  logic [AW-1:0] wr_base;
  logic          wr_en;
  logic          wr_bank_q;
  logic          wr_bank_d;
  logic          rd_bank_q;
  logic          rd_bank_d;

  logic [DW-1:0] pix_div_q;
  logic [DW-1:0] pix_div_d;
  logic [HW-1:0] h_q;
  logic [HW-1:0] h_d;
  rep_e          rep_q;
  rep_e          rep_d;
  logic          arm_q;
  logic          arm_d;
  logic          ovr_q;
  logic          ovr_d;
  logic [VW-1:0] vline_q;
  logic [VW-1:0] vline_d;
  logic          pix_tick;
  logic          wrap;

  logic          in_vs;
  logic          de0;
  logic          hs0;
  logic          vs0;
  logic [RW-1:0] rd_sum;
  logic [AW-1:0] rd_addr;

  logic [15:0]   rd_data_q;
  logic          de1_q;
  logic          hs1_q;
  logic          vs1_q;

  logic [7:0]    r_q;
  logic [7:0]    g_q;
  logic [7:0]    b_q;
  logic [7:0]    r_d;
  logic [7:0]    g_d;
  logic [7:0]    b_d;
  logic          de_q;
  logic          hs_q;
  logic          vs_q;

  function automatic logic [7:0] scale(
    input logic [3:0] c,
    input logic [3:0] i
  );
    return {4'd0, c} * ({4'd0, i} + 8'd1);
  endfunction

  assign hb_rise = hblank_b & ~hb_q;
  assign hb_fall = ~hblank_b & hb_q;
  assign vb_fall = ~vblank_b & vb_q;
  assign swap    = hb_fall & vblank_b;

  // Capture address: a new active line restarts at 0, overlong lines are clipped.
  always_comb begin
    wr_base   = hb_rise ? '0 : wr_addr_q;
    wr_en     = ~reset & pix_en & hblank_b & vblank_b
              & (wr_base < SRC_LIM);
    wr_addr_d = wr_en ? wr_base + ADDR_ONE : wr_base;
    wr_bank_d = swap ? ~wr_bank_q : wr_bank_q;
    rd_bank_d = swap ? wr_bank_q : rd_bank_q;
  end

  // Line buffer write port and synchronous read port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_bank_q][wr_base] <= vidout;
    end
    rd_data_q <= mem_q[rd_bank_q][rd_addr];
  end

  // Capture-side state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      hb_q      <= 1'b0;
      vb_q      <= 1'b0;
      wr_addr_q <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
    end else begin
      hb_q      <= hblank_b;
      vb_q      <= vblank_b;
      wr_addr_q <= wr_addr_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
    end
  end

  assign pix_tick = (pix_div_q == DIV_LAST);
  assign wrap     = pix_tick & (h_q == H_LAST);

  // Output timing and replay sequencing; a swap overrides a same-cycle wrap.
  always_comb begin
    pix_div_d = pix_div_q;
    h_d       = h_q;
    rep_d     = rep_q;
    arm_d     = arm_q;
    ovr_d     = ovr_q;
    vline_d   = vline_q;

    if (pix_tick) begin
      pix_div_d = '0;
      h_d       = wrap ? '0 : h_q + H_ONE;
    end else begin
      pix_div_d = pix_div_q + DIV_ONE;
    end

    if (wrap) begin
      unique case (rep_q)
        REP_FIRST: rep_d = REP_SECOND;
        REP_SECOND: begin
          rep_d = REP_IDLE;
          arm_d = 1'b1;
        end
        default: begin
          rep_d = REP_IDLE;
          if (arm_q) begin
            ovr_d = 1'b1;
          end
        end
      endcase
      if (vline_q != VS_DONE) begin
        vline_d = vline_q + VS_ONE;
      end
    end

    if (vb_fall) begin
      vline_d = '0;
    end

    if (swap) begin
      pix_div_d = '0;
      h_d       = '0;
      rep_d     = REP_FIRST;
      arm_d     = 1'b0;
    end
  end

  // Output timing state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pix_div_q <= '0;
      h_q       <= '0;
      rep_q     <= REP_IDLE;
      arm_q     <= 1'b0;
      ovr_q     <= 1'b0;
      vline_q   <= VS_DONE;
    end else begin
      pix_div_q <= pix_div_d;
      h_q       <= h_d;
      rep_q     <= rep_d;
      arm_q     <= arm_d;
      ovr_q     <= ovr_d;
      vline_q   <= vline_d;
    end
  end

  // Stage 0: visibility, syncs and buffer address from the h counter.
  always_comb begin
    in_vs  = (vline_q != '0) && (vline_q <= VS_LAST);
    de0    = (h_q < H_ACT) && (rep_q != REP_IDLE) && !in_vs;
    hs0    = !((h_q >= HS_BEG) && (h_q < HS_END));
    vs0    = !in_vs;
    rd_sum = RD_BASE + {1'b0, (h_q >> 1)};
    rd_addr = (rd_sum < RD_LIM) ? rd_sum[AW-1:0] : '0;
  end

  // Stage 1: controls ride alongside the buffer read.
  always_ff @(posedge clk) begin
    if (reset) begin
      de1_q <= 1'b0;
      hs1_q <= 1'b1;
      vs1_q <= 1'b1;
    end else begin
      de1_q <= de0;
      hs1_q <= hs0;
      vs1_q <= vs0;
    end
  end

  // Stage 2 colour expansion: channel * (intensity + 1), forced black when blanked.
  always_comb begin
    r_d = '0;
    g_d = '0;
    b_d = '0;
    if (de1_q) begin
      r_d = scale(rd_data_q[11:8], rd_data_q[15:12]);
      g_d = scale(rd_data_q[7:4], rd_data_q[15:12]);
      b_d = scale(rd_data_q[3:0], rd_data_q[15:12]);
    end
  end

  // Stage 2 output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q  <= '0;
      g_q  <= '0;
      b_q  <= '0;
      de_q <= 1'b0;
      hs_q <= 1'b1;
      vs_q <= 1'b1;
    end else begin
      r_q  <= r_d;
      g_q  <= g_d;
      b_q  <= b_d;
      de_q <= de1_q;
      hs_q <= hs1_q;
      vs_q <= vs1_q;
    end
  end

  assign vga_r        = r_q;
  assign vga_g        = g_q;
  assign vga_b        = b_q;
  assign vga_de       = de_q;
  assign vga_hsync_b  = hs_q;
  assign vga_vsync_b  = vs_q;
  assign line_overrun = ovr_q;

endmodule

// File: tb/tb_vid_scan_doubler.sv
// tb_vid_scan_doubler: scoreboard bench for the VGA line doubler.
// Source lines are driven, expected pixels queued, outputs captured and popped.
module tb_vid_scan_doubler;

  localparam int CROP = 8;
  localparam int LN   = 3200;
  localparam int NS   = 10000;

  logic        clk = 1'b0;
  logic        reset;
  logic        pix_en;
  logic [15:0] vidout;
  logic        hblank_b;
  logic        vblank_b;
  logic [7:0]  vga_r;
  logic [7:0]  vga_g;
  logic [7:0]  vga_b;
  logic        vga_hsync_b;
  logic        vga_vsync_b;
  logic        vga_de;
  logic        line_overrun;

  int errors = 0;
  int checks = 0;
  int nswap  = 0;

  logic [15:0] src_px [340];
  logic [23:0] exp_q [$];

  logic        s_de  [NS];
  logic [23:0] s_rgb [NS];
  logic        s_hs  [NS];
  logic        s_vs  [NS];
  logic        s_ov  [NS];

  vid_scan_doubler dut (
    .clk          (clk),
    .reset        (reset),
    .pix_en       (pix_en),
    .vidout       (vidout),
    .hblank_b     (hblank_b),
    .vblank_b     (vblank_b),
    .vga_r        (vga_r),
    .vga_g        (vga_g),
    .vga_b        (vga_b),
    .vga_hsync_b  (vga_hsync_b),
    .vga_vsync_b  (vga_vsync_b),
    .vga_de       (vga_de),
    .line_overrun (line_overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [23:0] conv(input logic [15:0] p);
    int ii, r, g, b;
    ii = int'(p[15:12]) + 1;
    r  = int'(p[11:8]) * ii;
    g  = int'(p[7:4]) * ii;
    b  = int'(p[3:0]) * ii;
    return {8'(r), 8'(g), 8'(b)};
  endfunction

  function automatic int cnt_de(input int lo, input int hi);
    int n = 0;
    for (int k = lo; k < hi; k++) if (s_de[k]) n++;
    return n;
  endfunction

  function automatic int cnt_hs_low(input int lo, input int hi);
    int n = 0;
    for (int k = lo; k < hi; k++) if (!s_hs[k]) n++;
    return n;
  endfunction

  task automatic drive_line(input int kind, input int n);
    logic [15:0] p;
    @(negedge clk) hblank_b = 1'b1;
    @(negedge clk);
    for (int k = 0; k < n; k++) begin
      case (kind)
        0:       p = 16'hF123;
        1:       p = {12'h000, k[3:0]};
        default: p = 16'hA000 | 16'(k);
      endcase
      if (k < 340) src_px[k] = p;
      vidout = p;
      pix_en = 1'b1;
      @(negedge clk) pix_en = 1'b0;
      @(negedge clk);
    end
    hblank_b = 1'b0;
    nswap++;
  endtask

  task automatic push_exp(input int reps);
    for (int r = 0; r < reps; r++)
      for (int x = 0; x < 640; x++)
        for (int c = 0; c < 4; c++)
          exp_q.push_back(conv(src_px[CROP + x / 2]));
  endtask

  task automatic collect(input int n, input int vb_drop);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      s_de[k]  = vga_de;
      s_rgb[k] = {vga_r, vga_g, vga_b};
      s_hs[k]  = vga_hsync_b;
      s_vs[k]  = vga_vsync_b;
      s_ov[k]  = line_overrun;
      if (k == vb_drop) vblank_b = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [27:0] got;
    int n;
    reset    = 1'b1;
    pix_en   = 1'b0;
    vidout   = 16'hFFFF;
    hblank_b = 1'b0;
    vblank_b = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      got = {vga_hsync_b, vga_vsync_b, vga_de, line_overrun,
             vga_r, vga_g, vga_b};
      checks++;
      if (got !== 28'hC000000) begin
        errors++;
        $display("FAIL reset_outputs cyc=%0d got %h want %h",
                 k, got, 28'hC000000);
      end
      pix_en = ~pix_en;
    end
    reset = 1'b0;
    n = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (vga_de || {vga_r, vga_g, vga_b} != 24'd0) n++;
      pix_en = ~pix_en;
    end
    pix_en = 1'b0;
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL blank_after_reset got %0d visible want 0", n);
    end
  endtask

  task automatic test_line();
    logic [23:0] e;
    int n, b;
    drive_line(0, 336);
    push_exp(2);
    collect(6500, -1);
    checks++;
    if (s_rgb[2] !== 24'h102030) begin
      errors++;
      $display("FAIL line_rgb got %h want %h", s_rgb[2], 24'h102030);
    end
    for (int l = 0; l < 2; l++) begin
      b = l * LN;
      n = cnt_de(b + 2, b + LN + 2);
      checks++;
      if (n != 2560) begin
        errors++;
        $display("FAIL line_de l=%0d got %0d want 2560", l, n);
      end
      n = cnt_hs_low(b + 2, b + LN + 2);
      checks++;
      if (n != 384) begin
        errors++;
        $display("FAIL hsync_len l=%0d got %0d want 384", l, n);
      end
      checks++;
      if ({s_hs[b+2625], s_hs[b+2626], s_hs[b+3009], s_hs[b+3010]}
          !== 4'b1001) begin
        errors++;
        $display("FAIL hsync_edges l=%0d got %b want 1001", l,
                 {s_hs[b+2625], s_hs[b+2626], s_hs[b+3009], s_hs[b+3010]});
      end
    end
    for (int k = 2; k < 6500; k++) begin
      if (s_de[k]) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL line_pix k=%0d got %h want none", k, s_rgb[k]);
        end else begin
          e = exp_q.pop_front();
          if (s_rgb[k] !== e) begin
            errors++;
            $display("FAIL line_pix k=%0d got %h want %h", k, s_rgb[k], e);
          end
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL line_left got %0d want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_ramp();
    logic [23:0] e;
    drive_line(1, 336);
    push_exp(1);
    collect(3200, -1);
    checks++;
    if ({s_de[1], s_de[2], s_de[2561], s_de[2562]} !== 4'b0110) begin
      errors++;
      $display("FAIL ramp_de_align got %b want 0110",
               {s_de[1], s_de[2], s_de[2561], s_de[2562]});
    end
    checks++;
    if (s_rgb[2] !== 24'h000008 || s_rgb[9] !== 24'h000008) begin
      errors++;
      $display("FAIL ramp_pair0 got %h/%h want 000008",
               s_rgb[2], s_rgb[9]);
    end
    checks++;
    if (s_rgb[10] !== 24'h000009 || s_rgb[17] !== 24'h000009) begin
      errors++;
      $display("FAIL ramp_pair1 got %h/%h want 000009",
               s_rgb[10], s_rgb[17]);
    end
    for (int k = 2; k < 3200; k++) begin
      if (s_de[k]) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL ramp_pix k=%0d got %h want none", k, s_rgb[k]);
        end else begin
          e = exp_q.pop_front();
          if (s_rgb[k] !== e) begin
            errors++;
            $display("FAIL ramp_pix k=%0d got %h want %h", k, s_rgb[k], e);
          end
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL ramp_left got %0d want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_overflow();
    int bk;
    logic [15:0] m;
    drive_line(2, 340);
    bk = (nswap - 1) % 2;
    @(negedge clk);
    checks++;
    if (dut.wr_addr_q !== 9'd336) begin
      errors++;
      $display("FAIL ovf_count got %0d want 336", dut.wr_addr_q);
    end
    m = dut.mem_q[bk][335];
    checks++;
    if (m !== src_px[335]) begin
      errors++;
      $display("FAIL ovf_last got %h want %h", m, src_px[335]);
    end
    m = dut.mem_q[bk][0];
    checks++;
    if (m !== src_px[0]) begin
      errors++;
      $display("FAIL ovf_first got %h want %h", m, src_px[0]);
    end
  endtask

  task automatic test_overrun();
    logic [23:0] e;
    int n;
    drive_line(2, 336);
    push_exp(2);
    collect(9800, -1);
    for (int l = 0; l < 3; l++) begin
      n = cnt_de(l * LN + 2, l * LN + LN + 2);
      checks++;
      if (n != ((l < 2) ? 2560 : 0)) begin
        errors++;
        $display("FAIL ovr_de l=%0d got %0d want %0d", l, n,
                 (l < 2) ? 2560 : 0);
      end
    end
    checks++;
    if ({s_ov[0], s_ov[9599], s_ov[9600], s_ov[9799]} !== 4'b0011) begin
      errors++;
      $display("FAIL ovr_flag got %b want 0011",
               {s_ov[0], s_ov[9599], s_ov[9600], s_ov[9799]});
    end
    for (int k = 2; k < 9800; k++) begin
      if (s_de[k]) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL ovr_pix k=%0d got %h want none", k, s_rgb[k]);
        end else begin
          e = exp_q.pop_front();
          if (s_rgb[k] !== e) begin
            errors++;
            $display("FAIL ovr_pix k=%0d got %h want %h", k, s_rgb[k], e);
          end
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL ovr_left got %0d want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_vsync();
    int n, both;
    drive_line(0, 336);
    collect(9800, 0);
    n = 0;
    both = 0;
    for (int k = 0; k < 9800; k++) begin
      if (!s_vs[k]) n++;
      if (!s_vs[k] && s_de[k]) both++;
    end
    checks++;
    if (n != 6400) begin
      errors++;
      $display("FAIL vsync_len got %0d want 6400", n);
    end
    checks++;
    if ({s_vs[3201], s_vs[3202], s_vs[9601], s_vs[9602]} !== 4'b1001) begin
      errors++;
      $display("FAIL vsync_edges got %b want 1001",
               {s_vs[3201], s_vs[3202], s_vs[9601], s_vs[9602]});
    end
    checks++;
    if (both != 0) begin
      errors++;
      $display("FAIL vsync_blank got %0d visible want 0", both);
    end
    n = cnt_de(2, 9800);
    checks++;
    if (n != 2560) begin
      errors++;
      $display("FAIL vsync_de got %0d want 2560", n);
    end
    checks++;
    if (s_ov[0] !== 1'b1) begin
      errors++;
      $display("FAIL ovr_sticky got %b want 1", s_ov[0]);
    end
  endtask

  task automatic test_reset_mid_vsync();
    logic [27:0] got;
    int n;
    logic seen;
    @(negedge clk) vblank_b = 1'b1;
    @(negedge clk);
    @(negedge clk) vblank_b = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 4000 && !seen; k++) begin
      @(negedge clk);
      if (!vga_vsync_b) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL mid_vsync_wait got timeout want vsync low");
    end
    reset = 1'b1;
    @(negedge clk);
    got = {vga_hsync_b, vga_vsync_b, vga_de, line_overrun,
           vga_r, vga_g, vga_b};
    checks++;
    if (got !== 28'hC000000) begin
      errors++;
      $display("FAIL mid_vsync_reset got %h want %h", got, 28'hC000000);
    end
    reset = 1'b0;
    n = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (!vga_vsync_b || vga_de) n++;
    end
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL post_reset_idle got %0d bad want 0", n);
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_ramp();
    test_overflow();
    test_overrun();
    test_vsync();
    test_reset_mid_vsync();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
